load_extend_ctrl: RTL and testbench
===================================

Name: load_extend_ctrl

Overview:
Load-path controller for the ID/MEM boundary. It accepts one load request at a time and checks alignment. It then issues a single word-aligned memory read and waits for the acknowledge, with a timeout. It selects the addressed byte or halfword lane, sign-extends or zero-extends it to 32 bits, and holds the result until the consumer accepts it. It is the sequencer that drives the 16→32 / 8→32 extension datapath for LB/LBU/LH/LHU/LW.

Parameters:
TIMEOUT, 16, cycles in WAIT_MEM without mem_ack before the access is aborted with an error (legal range 2..255).
CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  reset; synchronous and active-low.
req_valid  in  1  load request present.
req_ready  out  1  controller can accept a request (IDLE only).
req_addr  in  32  byte address.
req_size  in  2  0=byte, 1=halfword, 2=word, 3=illegal.
req_signed  in  1  1=sign-extend, 0=zero-extend (ignored for word).
mem_req  out  1  memory read strobe, level-held until mem_ack.
mem_addr  out  32  {req_addr[31:2], 2'b00}, registered.
mem_ack  in  1  read data valid this cycle.
mem_rdata  in  32  little-endian read word.
rsp_valid  out  1  result available.
rsp_ready  in  1  consumer accepts result.
rsp_data  out  32  extended load result.
rsp_err  out  1  misaligned, illegal size, or timeout.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. req_ready=1, mem_req=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0, timeout counter=0. Reset overrides everything, including mid-WAIT_MEM: mem_req drops the next cycle and a late mem_ack is ignored.
- States: IDLE, WAIT_MEM, RESP. req_ready=(state==IDLE), combinational from state. mem_req and rsp_valid are registered.
- IDLE + req_valid: latch addr[1:0], size and signed.
  - Fault if size==3, or size==1 with addr[0]=1, or size==2 with addr[1:0]!=0. On a fault: go to RESP with rsp_err=1 and rsp_data=0. No memory access is made.
  - Otherwise: mem_addr is set to the aligned address, mem_req=1, counter=0, and the state moves to WAIT_MEM.
- WAIT_MEM:
  - mem_req stays 1. The counter increments every cycle without an ack.
  - If mem_ack=1: capture the extended data into rsp_data, set rsp_err=0, drop mem_req, and go to RESP. rsp_valid asserts the following cycle.
  - If the counter reaches TIMEOUT-1 with no ack: drop mem_req, set rsp_data=0, rsp_err=1, and go to RESP.
  - If ack and timeout occur in the same cycle, the ack wins.
- Extraction:
  - Byte lane = mem_rdata[8*a+7:8*a], where a=addr[1:0].
  - Half lane = mem_rdata[16*h+15:16*h], where h=addr[1].
  - Signed: replicate bit 7 (byte) or bit 15 (half) into the upper bits. Unsigned: upper bits are 0.
  - Word: passed through unchanged.
- RESP: rsp_valid=1. rsp_data and rsp_err are stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1, clear rsp_valid and go to IDLE.
  - rsp_data/rsp_err keep their last values after the handshake.
- Request timing:
  - No request is accepted in the handshake cycle. The earliest next req_valid acceptance is the cycle after the handshake.
  - Minimum latency from request acceptance to rsp_valid: 2 cycles (accept, ack in the first WAIT_MEM cycle, rsp_valid asserted).
  - Faults reach rsp_valid 1 cycle after acceptance.
- mem_ack outside WAIT_MEM is ignored.

Test Plan:
1. Reset then LB signed, addr 0x103, mem_rdata 0x80FF1234 with ack on the 1st WAIT cycle -> mem_addr=0x100, rsp_data=0xFFFFFF80, rsp_err=0, rsp_valid 2 cycles after acceptance.
2. LHU addr 0x202, rdata 0xF0000001 -> rsp_data=0x0000F000; then LH signed with the same values -> 0xFFFFF000; LH addr 0x200 -> 0x00000001.
3. LW addr 0x301 -> no mem_req, rsp_err=1, rsp_data=0 one cycle after acceptance. Also req_size=3 at addr 0x300 -> rsp_err=1.
4. LW addr 0x400 with mem_ack never asserted, TIMEOUT=16 -> mem_req high for exactly 16 cycles, then rsp_err=1 and rsp_data=0. A mem_ack on the timeout cycle instead gives rsp_err=0 and the data.
5. Backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 -> req_ready=0, rsp_data stable. Release -> IDLE, and the next request is accepted the following cycle.
6. Assert rst_n=0 during WAIT_MEM, then pulse mem_ack after reset -> all outputs return to their reset values and no rsp_valid is produced.

Source files
------------

// File: rtl/load_extend_ctrl.sv
// rtl/load_extend_ctrl.sv - load sequencer: alignment check, aligned word read with timeout, lane select and extension
module load_extend_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    RESP
  } state_t;

  localparam logic [1:0]       SZ_BYTE  = 2'd0;
  localparam logic [1:0]       SZ_HALF  = 2'd1;
  localparam logic [1:0]       SZ_WORD  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [1:0]       lane;
  logic [1:0]       size;
  logic             sgn;
  logic [CNT_W-1:0] cnt;
  logic             fault;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      ext_data;

  assign req_ready = (state == IDLE);

  always_comb begin
    fault = 1'b0;
    case (req_size)
      SZ_BYTE: fault = 1'b0;
      SZ_HALF: fault = req_addr[0];
      SZ_WORD: fault = |req_addr[1:0];
      default: fault = 1'b1;
    endcase
  end

  // Lane selection uses the offset latched at acceptance, not the live request bus.
  always_comb begin
    byte_sel = 8'h00;
    case (lane)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext_data = mem_rdata;
    case (size)
      SZ_BYTE: ext_data = {{24{sgn & byte_sel[7]}}, byte_sel};
      SZ_HALF: ext_data = {{16{sgn & half_sel[15]}}, half_sel};
      default: ext_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lane      <= 2'd0;
      size      <= 2'd0;
      sgn       <= 1'b0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lane <= req_addr[1:0];
            size <= req_size;
            sgn  <= req_signed;
            if (fault) begin
              rsp_data  <= 32'h0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              mem_req  <= 1'b1;
              cnt      <= '0;
              state    <= WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          // An ack arriving on the last counted cycle still completes the load.
          if (mem_ack) begin
            rsp_data  <= ext_data;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            mem_req   <= 1'b0;
            state     <= RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_data  <= 32'h0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            mem_req   <= 1'b0;
            state     <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_extend_ctrl.sv
// tb/tb_load_extend_ctrl.sv - randomized self-checking bench for load_extend_ctrl against a transaction-level model
module tb_load_extend_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;

  always #5 clk = ~clk;

  load_extend_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_signed(req_signed),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_on = 1'b0;
  logic [31:0] exp_data = 32'h0;
  logic [31:0] exp_maddr = 32'h0;
  logic        exp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic bit model_fault(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    return (a % (32'd1 << sz)) != 32'd0;
  endfunction

  function automatic logic [31:0] model_ext(input logic [31:0] a, input logic [1:0] sz,
                                            input logic sg, input logic [31:0] rd);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = (rd >> (8 * a[1:0])) & 32'hFF;
        if (sg && v >= 32'd128) v = v - 32'd256;
      end
      2'd1: begin
        v = (rd >> (16 * a[1])) & 32'hFFFF;
        if (sg && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      if (rsp_valid) begin
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      end
      if (mem_req) chk("mem_addr", mem_addr, exp_maddr);
      chk("req_ready_vs_busy", 32'(req_ready), 32'(!(rsp_valid || mem_req)));
    end
  end

  // Starts and ends at a falling edge with the DUT idle.
  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                         input logic [31:0] rd, input int ack_at, input int hold,
                         input bit use_lit, input logic [31:0] lit);
    bit fault, acked;
    int n_req, lat, want_req, want_lat;
    fault     = model_fault(a, sz);
    acked     = !fault && ack_at >= 0 && ack_at < TIMEOUT;
    exp_maddr = {a[31:2], 2'b00};
    exp_err   = !acked;
    exp_data  = acked ? model_ext(a, sz, sg, rd) : 32'h0;
    want_req  = fault ? 0 : (acked ? ack_at + 1 : TIMEOUT);
    want_lat  = want_req + 1;

    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_signed = sg;
    @(posedge clk); #1;
    req_valid = 1'(($urandom() & 1));
    req_addr = $urandom(); req_size = 2'($urandom_range(0, 3)); req_signed = 1'($urandom_range(0, 1));

    n_req = 0; lat = 0;
    for (int c = 1; c <= TIMEOUT + 8; c++) begin
      if (acked) mem_ack = (c - 1 == ack_at);
      else mem_ack = fault ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = (acked && mem_ack) ? rd : $urandom();
      @(negedge clk);
      if (mem_req) n_req++;
      if (rsp_valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("rsp_latency", 32'(lat), 32'(want_lat));
    chk("mem_req_cycles", 32'(n_req), 32'(want_req));
    if (use_lit) chk("rsp_data_literal", rsp_data, lit);

    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom();
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end

    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = $urandom(); mem_ack = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0; mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("post_mem_req", 32'(mem_req), 32'd0);
    chk("keep_rsp_data", rsp_data, exp_data);
    chk("keep_rsp_err", 32'(rsp_err), 32'(exp_err));
    mem_ack = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'h0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  initial begin
    int r, ack_at;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset_state("reset");
    mon_on = 1'b1;

    do_load(32'h103, 2'd0, 1'b1, 32'h80FF1234, 0, 0, 1'b1, 32'hFFFFFF80);
    chk("lb_mem_addr_literal", exp_maddr, 32'h100);
    do_load(32'h202, 2'd1, 1'b0, 32'hF0000001, 0, 0, 1'b1, 32'h0000F000);
    do_load(32'h202, 2'd1, 1'b1, 32'hF0000001, 0, 0, 1'b1, 32'hFFFFF000);
    do_load(32'h200, 2'd1, 1'b1, 32'hF0000001, 1, 0, 1'b1, 32'h00000001);
    do_load(32'h301, 2'd2, 1'b0, 32'h11111111, 0, 0, 1'b1, 32'h0);
    chk("lw_misaligned_err", 32'(rsp_err), 32'd1);
    do_load(32'h300, 2'd3, 1'b0, 32'h22222222, 0, 0, 1'b1, 32'h0);
    chk("size3_err", 32'(rsp_err), 32'd1);
    do_load(32'h400, 2'd2, 1'b0, 32'hDEADBEEF, -1, 0, 1'b1, 32'h0);
    chk("timeout_err", 32'(rsp_err), 32'd1);
    do_load(32'h400, 2'd2, 1'b0, 32'hDEADBEEF, TIMEOUT - 1, 0, 1'b1, 32'hDEADBEEF);
    chk("ack_on_timeout_err", 32'(rsp_err), 32'd0);
    do_load(32'h104, 2'd2, 1'b0, 32'h12345678, 2, 5, 1'b1, 32'h12345678);
    do_load(32'h501, 2'd0, 1'b0, 32'hA5C3817E, 0, 0, 1'b1, 32'h00000081);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7) ack_at = $urandom_range(0, 4);
      else if (r == 7) ack_at = -1;
      else if (r == 8) ack_at = TIMEOUT - 1;
      else ack_at = $urandom_range(5, TIMEOUT - 2);
      do_load($urandom(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom(),
              ack_at, $urandom_range(0, 3), 1'b0, 32'h0);
    end

    mon_on = 1'b0;
    req_valid = 1'b1; req_addr = 32'h500; req_size = 2'd2; req_signed = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk_reset_state("midwait_reset");
    @(posedge clk); #1 mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("late_ack_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("late_ack_mem_req", 32'(mem_req), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
